uart_tx_core: RTL and testbench

//  UART transmitter: serialises one parallel byte per frame onto TX_OUT.

---
 rtl/uart_tx_core.sv | 84 ++++++++
 tb/tb_uart_tx_core.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter, start + LSB-first data + optional parity + stop, PRESCALE cycles per bit
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    input  logic [5:0]            i_prescale,
    output logic                  o_data_ack,
    output logic                  o_tx_out,
    output logic                  o_busy
);
    localparam int BW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t                r_state, w_state;
    logic [5:0]            r_cnt, w_cnt, r_pm1, w_pm1;
    logic [BW-1:0]         r_bit, w_bit;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic                  r_par, w_par, r_par_en, w_par_en, w_last, w_accept, w_tx;
    always_comb begin
        w_last   = r_cnt == r_pm1;
        w_accept = i_data_valid && (r_state == S_IDLE || (r_state == S_STOP && w_last));
        w_state  = r_state;
        w_cnt    = (r_state == S_IDLE || w_last) ? 6'd0 : r_cnt + 6'd1;
        w_bit    = r_bit;
        w_shift  = r_shift;
        w_par    = r_par;
        w_par_en = r_par_en;
        w_pm1    = r_pm1;
        case (r_state)
            S_IDLE:   if (w_accept) w_state = S_START;
            S_START:  if (w_last) begin
                w_state = S_DATA;
                w_bit   = '0;
            end
            S_DATA:   if (w_last) begin
                w_shift = r_shift >> 1;
                w_bit   = r_bit + 1'b1;
                if (r_bit == BW'(DATA_WIDTH - 1)) w_state = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_last) w_state = S_STOP;
            S_STOP:   if (w_last) w_state = w_accept ? S_START : S_IDLE;
            default:  w_state = S_IDLE;
        endcase
        // the accept may come from IDLE or the final STOP cycle; both latch a fresh frame
        if (w_accept) begin
            w_shift  = i_p_data;
            w_par    = ^i_p_data ^ i_par_typ;
            w_par_en = i_par_en;
            w_pm1    = (i_prescale == 6'd0) ? 6'd0 : i_prescale - 6'd1;
        end
        w_tx = w_state == S_START  ? 1'b0 :
               w_state == S_DATA   ? w_shift[0] :
               w_state == S_PARITY ? w_par : 1'b1;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_par_en   <= 1'b0;
            r_pm1      <= '0;
            o_data_ack <= 1'b0;
            o_tx_out   <= 1'b1;
            o_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit      <= w_bit;
            r_shift    <= w_shift;
            r_par      <= w_par;
            r_par_en   <= w_par_en;
            r_pm1      <= w_pm1;
            o_data_ack <= w_accept;
            o_tx_out   <= w_tx;
            o_busy     <= w_state != S_IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: cycle-exact scoreboard check of uart_tx_core serial output, busy and ack
module tb_uart_tx_core;
    logic       clk = 1'b0, rst = 1'b1, dv = 1'b0, pe = 1'b0, pt = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [5:0] ps = 6'd0;
    logic       ack, tx, busy;
    int         n_assert = 0, n_fail = 0;
    logic       q_tx[$], q_busy[$], q_ack[$];
    logic [7:0] q_next[$];

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_p_data(pd), .i_data_valid(dv),
        .i_par_en(pe), .i_par_typ(pt), .i_prescale(ps),
        .o_data_ack(ack), .o_tx_out(tx), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic e, input logic t, input logic [5:0] p);
        int   n;
        logic b[$];
        n = (p == 6'd0) ? 1 : int'(p);
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (e) b.push_back(^d ^ t);
        b.push_back(1'b1);
        for (int j = 0; j < b.size(); j++)
            for (int k = 0; k < n; k++) begin
                q_tx.push_back(b[j]);
                q_busy.push_back(1'b1);
                q_ack.push_back(j == 0 && k == 0);
            end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            q_tx.push_back(1'b1);
            q_busy.push_back(1'b0);
            q_ack.push_back(1'b0);
        end
    endtask

    task automatic drain(input int poke, input int max);
        logic e_ack;
        for (int c = 0; c < max && q_tx.size() > 0; c++) begin
            @(posedge clk); #1;
            e_ack = q_ack.pop_front();
            chk("tx", tx, q_tx.pop_front());
            chk("busy", busy, q_busy.pop_front());
            chk("ack", ack, e_ack);
            if (e_ack) begin
                if (q_next.size() > 0) pd = q_next.pop_front();
                else dv = 1'b0;
            end
            if (c == poke) begin
                dv = 1'b1;
                pe = ~pe;
                pd = ~pd;
            end
            if (c == poke + 1) dv = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 1'b0);
        rst = 1'b0;
        // plain frame, no parity
        pd = 8'hA5; pe = 1'b0; pt = 1'b0; ps = 6'd8; dv = 1'b1;
        push_frame(8'hA5, 1'b0, 1'b0, 6'd8);
        push_idle(3);
        drain(-10, 1000);
        // even then odd parity
        pd = 8'hA5; pe = 1'b1; pt = 1'b0; ps = 6'd4; dv = 1'b1;
        push_frame(8'hA5, 1'b1, 1'b0, 6'd4);
        push_idle(3);
        drain(-10, 1000);
        pd = 8'hA5; pe = 1'b1; pt = 1'b1; ps = 6'd4; dv = 1'b1;
        push_frame(8'hA5, 1'b1, 1'b1, 6'd4);
        push_idle(3);
        drain(-10, 1000);
        // back-to-back frames with valid held high
        pd = 8'h3C; pe = 1'b0; pt = 1'b0; ps = 6'd8; dv = 1'b1;
        q_next.push_back(8'hC3);
        push_frame(8'h3C, 1'b0, 1'b0, 6'd8);
        push_frame(8'hC3, 1'b0, 1'b0, 6'd8);
        push_idle(3);
        drain(-10, 1000);
        // valid pulse and parity-enable toggle mid-DATA are ignored
        pd = 8'h3C; pe = 1'b0; pt = 1'b0; ps = 6'd8; dv = 1'b1;
        push_frame(8'h3C, 1'b0, 1'b0, 6'd8);
        push_idle(3);
        drain(30, 1000);
        // minimum bit period, PRESCALE 1 and 0
        pd = 8'hFF; pe = 1'b0; pt = 1'b0; ps = 6'd1; dv = 1'b1;
        push_frame(8'hFF, 1'b0, 1'b0, 6'd1);
        push_idle(3);
        drain(-10, 1000);
        pd = 8'hFF; pe = 1'b0; pt = 1'b0; ps = 6'd0; dv = 1'b1;
        push_frame(8'hFF, 1'b0, 1'b0, 6'd0);
        push_idle(3);
        drain(-10, 1000);
        // reset in the middle of DATA aborts the frame
        pd = 8'hA5; pe = 1'b0; pt = 1'b0; ps = 6'd2; dv = 1'b1;
        push_frame(8'hA5, 1'b0, 1'b0, 6'd2);
        drain(-10, 12);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ack", ack, 1'b0);
        q_tx.delete(); q_busy.delete(); q_ack.delete();
        rst = 1'b0;
        push_idle(10);
        drain(-10, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
